// File: rtl/cc_line_fill_deserializer.sv
// Cache fill path: gathers an 8-beat wrap-order AXI R burst into one aligned 512b line
// and hands it, with its tag/index, to the array write port.
module cc_line_fill_deserializer #(
  parameter int unsigned TAG_WIDTH   = 17,
  parameter int unsigned INDEX_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fill_req_valid_i,
  output logic                   fill_req_ready_o,
  input  logic [2:0]             fill_req_word_i,
  input  logic [TAG_WIDTH-1:0]   fill_req_tag_i,
  input  logic [INDEX_WIDTH-1:0] fill_req_index_i,
  input  logic [63:0]            mem_rdata_i,
  input  logic                   mem_rlast_i,
  input  logic                   mem_rvalid_i,
  output logic                   mem_rready_o,
  output logic                   line_valid_o,
  input  logic                   line_ready_i,
  output logic [511:0]           line_data_o,
  output logic [TAG_WIDTH-1:0]   line_tag_o,
  output logic [INDEX_WIDTH-1:0] line_index_o,
  output logic                   fill_err_o
);

  typedef enum logic [1:0] {StIdle, StCollect, StWrite} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             cnt_q;
  logic [2:0]             start_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [7:0][63:0]       line_q;
  logic                   err_q;

  logic       req_fire;
  logic       beat_fire;
  logic       line_fire;
  logic [2:0] slot;
  logic       last_beat;

  assign req_fire  = fill_req_valid_i & (state_q == StIdle);
  assign beat_fire = mem_rvalid_i & (state_q == StCollect);
  assign line_fire = line_ready_i & (state_q == StWrite);
  assign last_beat = (cnt_q == 3'd7);
  // 3-bit add gives the wrap-burst slot for free
  assign slot      = start_q + cnt_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (fill_req_valid_i) state_d = StCollect;
      StCollect: if (mem_rvalid_i && last_beat) state_d = StWrite;
      StWrite:   if (line_ready_i) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Request latch, beat counter, line buffer and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 3'd0;
      start_q <= 3'd0;
      tag_q   <= '0;
      index_q <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (req_fire) begin
        cnt_q   <= 3'd0;
        start_q <= fill_req_word_i;
        tag_q   <= fill_req_tag_i;
        index_q <= fill_req_index_i;
      end
      if (beat_fire) begin
        line_q[slot] <= mem_rdata_i;
        cnt_q        <= cnt_q + 3'd1;
        // rlast must mark exactly the 8th beat
        if (mem_rlast_i != last_beat) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // Outputs; ready is held low while reset is asserted
  always_comb begin
    fill_req_ready_o = rst_n && (state_q == StIdle);
    mem_rready_o     = (state_q == StCollect);
    line_valid_o     = (state_q == StWrite);
    line_data_o      = line_q;
    line_tag_o       = tag_q;
    line_index_o     = index_q;
    fill_err_o       = err_q;
  end

  logic unused_line_fire;
  assign unused_line_fire = line_fire;

endmodule

// File: tb/tb_cc_line_fill_deserializer.sv
// Directed-plus-random bench for cc_line_fill_deserializer; a line/err model built from
// the wrap-order and rlast rules predicts every checked output.
module tb_cc_line_fill_deserializer;

  localparam int unsigned TW = 17;
  localparam int unsigned IW = 9;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           fill_req_valid_i;
  logic           fill_req_ready_o;
  logic [2:0]     fill_req_word_i;
  logic [TW-1:0]  fill_req_tag_i;
  logic [IW-1:0]  fill_req_index_i;
  logic [63:0]    mem_rdata_i;
  logic           mem_rlast_i;
  logic           mem_rvalid_i;
  logic           mem_rready_o;
  logic           line_valid_o;
  logic           line_ready_i;
  logic [511:0]   line_data_o;
  logic [TW-1:0]  line_tag_o;
  logic [IW-1:0]  line_index_o;
  logic           fill_err_o;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  cc_line_fill_deserializer #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fill_req_valid_i (fill_req_valid_i),
    .fill_req_ready_o (fill_req_ready_o),
    .fill_req_word_i  (fill_req_word_i),
    .fill_req_tag_i   (fill_req_tag_i),
    .fill_req_index_i (fill_req_index_i),
    .mem_rdata_i      (mem_rdata_i),
    .mem_rlast_i      (mem_rlast_i),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rready_o     (mem_rready_o),
    .line_valid_o     (line_valid_o),
    .line_ready_i     (line_ready_i),
    .line_data_o      (line_data_o),
    .line_tag_o       (line_tag_o),
    .line_index_o     (line_index_o),
    .fill_err_o       (fill_err_o)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full fill. early_last: beat index carrying a premature rlast (-1 = none).
  // hold_next: keep the next request asserted during WRITE.
  task automatic run_fill(input logic [2:0] sw, input logic [TW-1:0] tag, input logic [IW-1:0] idx,
                          input bit seq_data, input int gap_pct, input int early_last,
                          input bit drop_last, input int ready_hold, input bit hold_next,
                          input logic [2:0] nsw, input logic [TW-1:0] ntag,
                          input logic [IW-1:0] nidx);
    logic [63:0]  beats[8];
    logic [511:0] exp_line;
    logic         rl;
    int           gaps;
    for (int b = 0; b < 8; b++) begin
      beats[b] = seq_data ? {56'hC0FFEE_0000_0000, 8'(b)} : {$urandom, $urandom};
      exp_line[64*((sw + b) % 8) +: 64] = beats[b];
    end
    chk("req_ready_idle", fill_req_ready_o, 1'b1);
    fill_req_valid_i = 1'b1;
    fill_req_word_i  = sw;
    fill_req_tag_i   = tag;
    fill_req_index_i = idx;
    tick();
    fill_req_valid_i = 1'b0;
    fill_req_tag_i   = TW'($urandom);
    fill_req_index_i = IW'($urandom);
    chk("rready_first_collect", mem_rready_o, 1'b1);
    chk("req_ready_collect", fill_req_ready_o, 1'b0);
    for (int b = 0; b < 8; b++) begin
      gaps = 0;
      while (($urandom % 100) < gap_pct && gaps < 20) begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = {$urandom, $urandom};
        mem_rlast_i  = 1'($urandom);
        tick();
        chk("rready_gap", mem_rready_o, 1'b1);
        chk("line_valid_gap", line_valid_o, 1'b0);
        gaps++;
      end
      rl = (b == 7 && !drop_last) || (b == early_last);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = beats[b];
      mem_rlast_i  = rl;
      tick();
      if ((b < 7 && rl) || (b == 7 && !rl)) exp_err = 1'b1;
      chk("err_after_beat", fill_err_o, exp_err);
      if (b < 7) chk("line_valid_collect", line_valid_o, 1'b0);
    end
    mem_rvalid_i = 1'b0;
    mem_rlast_i  = 1'b0;
    chk("line_valid_latency", line_valid_o, 1'b1);
    chk("rready_drop", mem_rready_o, 1'b0);
    chk("line_data", line_data_o, exp_line);
    chk("line_tag", line_tag_o, tag);
    chk("line_index", line_index_o, idx);
    if (hold_next) begin
      fill_req_valid_i = 1'b1;
      fill_req_word_i  = nsw;
      fill_req_tag_i   = ntag;
      fill_req_index_i = nidx;
    end
    for (int h = 0; h < ready_hold; h++) begin
      line_ready_i = 1'b0;
      mem_rvalid_i = 1'($urandom);
      mem_rdata_i  = {$urandom, $urandom};
      tick();
      chk("hold_valid", line_valid_o, 1'b1);
      chk("hold_data", line_data_o, exp_line);
      chk("hold_tag", line_tag_o, tag);
      chk("hold_index", line_index_o, idx);
      chk("hold_req_ready", fill_req_ready_o, 1'b0);
      chk("hold_rready", mem_rready_o, 1'b0);
    end
    mem_rvalid_i = 1'b0;
    line_ready_i = 1'b1;
    tick();
    line_ready_i = 1'b0;
    chk("valid_after_hs", line_valid_o, 1'b0);
    chk("err_after_line", fill_err_o, exp_err);
  endtask

  initial begin
    logic [2:0]    sw;
    logic [TW-1:0] t0, t1;
    logic [IW-1:0] i0, i1;
    rst_n = 1'b0;
    fill_req_valid_i = 1'b0;
    fill_req_word_i  = '0;
    fill_req_tag_i   = '0;
    fill_req_index_i = '0;
    mem_rdata_i      = '0;
    mem_rlast_i      = 1'b0;
    mem_rvalid_i     = 1'b0;
    line_ready_i     = 1'b0;
    #12;
    chk("rst_req_ready", fill_req_ready_o, 1'b0);
    chk("rst_line_valid", line_valid_o, 1'b0);
    chk("rst_line_data", line_data_o, '0);
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready", fill_req_ready_o, 1'b1);
    chk("rel_err", fill_err_o, 1'b0);
    tick();

    // Stray beat while idle must be ignored
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    mem_rvalid_i = 1'b0;
    chk("idle_rready", mem_rready_o, 1'b0);
    chk("idle_stay", fill_req_ready_o, 1'b1);
    chk("idle_data", line_data_o, '0);

    run_fill(3'd0, 17'h1ABCD, 9'h155, 1'b1, 0, -1, 1'b0, 0, 1'b0, 3'd0, '0, '0);
    tick();
    run_fill(3'd5, 17'h0F0F0, 9'h0AA, 1'b0, 0, -1, 1'b0, 2, 1'b0, 3'd0, '0, '0);
    tick();
    run_fill(3'($urandom), TW'($urandom), IW'($urandom), 1'b0, 50, -1, 1'b0, 10, 1'b0, 3'd0, '0, '0);
    tick();
    run_fill(3'($urandom), TW'($urandom), IW'($urandom), 1'b0, 30, 3, 1'b0, 1, 1'b0, 3'd0, '0, '0);
    tick();
    run_fill(3'($urandom), TW'($urandom), IW'($urandom), 1'b0, 20, -1, 1'b1, 0, 1'b0, 3'd0, '0, '0);
    tick();

    // Reset after three beats of a burst
    sw = 3'($urandom);
    fill_req_valid_i = 1'b1;
    fill_req_word_i  = sw;
    fill_req_tag_i   = TW'($urandom);
    fill_req_index_i = IW'($urandom);
    tick();
    fill_req_valid_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = {$urandom, $urandom};
      tick();
    end
    mem_rvalid_i = 1'b0;
    rst_n = 1'b0;
    #2;
    exp_err = 1'b0;
    chk("mid_rst_req_ready", fill_req_ready_o, 1'b0);
    chk("mid_rst_rready", mem_rready_o, 1'b0);
    chk("mid_rst_valid", line_valid_o, 1'b0);
    chk("mid_rst_data", line_data_o, '0);
    chk("mid_rst_tag", line_tag_o, '0);
    chk("mid_rst_index", line_index_o, '0);
    chk("mid_rst_err", fill_err_o, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_req_ready", fill_req_ready_o, 1'b1);
    tick();
    run_fill(3'd2, TW'($urandom), IW'($urandom), 1'b0, 25, -1, 1'b0, 0, 1'b0, 3'd0, '0, '0);
    tick();

    // Back-to-back fills with the second request held during WRITE
    t0 = TW'($urandom);
    i0 = IW'($urandom);
    t1 = TW'($urandom);
    i1 = IW'($urandom);
    sw = 3'($urandom);
    run_fill(3'($urandom), t0, i0, 1'b0, 10, -1, 1'b0, 3, 1'b1, sw, t1, i1);
    run_fill(sw, t1, i1, 1'b0, 10, -1, 1'b0, 0, 1'b0, 3'd0, '0, '0);
    tick();

    for (int k = 0; k < 4; k++) begin
      run_fill(3'($urandom), TW'($urandom), IW'($urandom), 1'b0, 40, -1, 1'b0,
               int'($urandom_range(0, 4)), 1'b0, 3'd0, '0, '0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
